// File: rtl/srv_icache_refill.sv
// Instruction-cache line-refill engine.
// Takes one line-fill request, reads the four 32-bit words of the line from a
// request/grant memory port (critical word first, bounded reads in flight) and
// returns the assembled 128-bit line with a single-cycle response pulse.
module srv_icache_refill #(
  parameter int MAX_OUTST = 4,
  parameter bit CWF_EN    = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ext_req_i,
  input  logic [31:0]  ext_addr_i,
  output logic         ext_rsp_o,
  output logic [127:0] ext_data_o,
  output logic         busy_o,
  output logic         mem_req_o,
  output logic [31:0]  mem_addr_o,
  input  logic         mem_gnt_i,
  input  logic [31:0]  mem_rdata_i,
  input  logic         mem_rvalid_i
);

  localparam logic [2:0] LP_MAX_OUTST = 3'(MAX_OUTST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       r_state;
  logic [29:0]  r_line;
  logic [1:0]   r_start;
  logic [2:0]   r_issued;
  logic [2:0]   r_returned;
  logic [127:0] r_line_buf;

  logic [2:0]   w_outst;
  logic [1:0]   w_iss_word;
  logic [1:0]   w_ret_word;
  logic         w_req;
  logic         w_gnt;
  logic         w_ret;

  // Request qualification from registered counters only; grant/rvalid just
  // decide which counters advance at the next edge.
  always_comb begin
    w_outst    = r_issued - r_returned;
    w_iss_word = r_start + r_issued[1:0];
    w_ret_word = r_start + r_returned[1:0];
    w_req      = (r_state == S_FILL) && (r_issued < 3'd4) &&
                 (w_outst < LP_MAX_OUTST);
    w_gnt      = w_req && mem_gnt_i;
    // An rvalid with nothing outstanding is spurious and dropped.
    w_ret      = (r_state == S_FILL) && mem_rvalid_i && (r_returned < r_issued);
  end

  // Fill FSM: capture the line, count issued/returned reads, write lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_line     <= '0;
      r_start    <= '0;
      r_issued   <= '0;
      r_returned <= '0;
      r_line_buf <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ext_req_i) begin
            r_line     <= ext_addr_i[31:2];
            r_start    <= CWF_EN ? ext_addr_i[1:0] : 2'd0;
            r_issued   <= '0;
            r_returned <= '0;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_gnt) begin
            r_issued <= r_issued + 3'd1;
          end
          if (w_ret) begin
            r_line_buf[{w_ret_word, 5'd0} +: 32] <= mem_rdata_i;
            r_returned <= r_returned + 3'd1;
            if (r_returned == 3'd3) begin
              r_state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ext_rsp_o  = (r_state == S_RESP);
  assign busy_o     = (r_state != S_IDLE);
  assign mem_req_o  = w_req;
  assign mem_addr_o = {r_line, w_iss_word};
  assign ext_data_o = r_line_buf;

endmodule

// File: tb/tb_srv_icache_refill.sv
// Bench for srv_icache_refill: three instances (MAX_OUTST=4/CWF, MAX_OUTST=1/CWF,
// MAX_OUTST=4/no-CWF), each with its own memory model, address scoreboard and
// line scoreboard. Stimulus pushes expected addresses/lines; the models and
// monitors pop and compare as the DUTs present grants and responses.
module tb_srv_icache_refill;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc  = 0;
  int   nvec = 0;
  int   nmis = 0;

  logic         ext_req  [3];
  logic [31:0]  ext_addr [3];
  logic         ext_rsp  [3];
  logic [127:0] ext_data [3];
  logic         busy     [3];
  logic         mem_req  [3];
  logic [31:0]  mem_addr [3];

  int gnt_pct [3];
  int dmin    [3];
  int dmax    [3];
  bit spur    [3];

  logic [31:0]  exp_addr [3][$];
  logic [127:0] exp_line [3][$];
  int           gnt_log  [3][$];
  int           rsp_cnt  [3];
  int           rv_cnt   [3];
  logic [127:0] last_line[3];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA000_0000;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar G = 0; G < 3; G++) begin : g_dut
    localparam int MAXO = (G == 1) ? 1 : 4;
    localparam bit CWF  = (G == 2) ? 1'b0 : 1'b1;

    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [31:0] pd[$];
    int          pt[$];
    int          last_due = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    srv_icache_refill #(.MAX_OUTST(MAXO), .CWF_EN(CWF)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ext_req_i    (ext_req[G]),
      .ext_addr_i   (ext_addr[G]),
      .ext_rsp_o    (ext_rsp[G]),
      .ext_data_o   (ext_data[G]),
      .busy_o       (busy[G]),
      .mem_req_o    (mem_req[G]),
      .mem_addr_o   (mem_addr[G]),
      .mem_gnt_i    (gnt),
      .mem_rdata_i  (rdata),
      .mem_rvalid_i (rvalid)
    );

    // Memory model: random grants, in-order delayed read data, checks on
    // issued address, outstanding bound and request/address hold while stalled.
    always @(negedge clk) begin : p_model
      bit popped;
      int d;
      int due;
      int inflight;
      if (!rst_n) begin
        pd.delete();
        pt.delete();
        gnt        = 1'b0;
        rvalid     = 1'b0;
        last_due   = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk($sformatf("stall_req%0d", G), mem_req[G], 1'b1);
          chk($sformatf("stall_addr%0d", G), mem_addr[G], prev_addr);
        end
        popped = 1'b0;
        rvalid = 1'b0;
        rdata  = 32'h0;
        if (pt.size() != 0 && pt[0] <= cyc) begin
          rvalid = 1'b1;
          rdata  = pd.pop_front();
          void'(pt.pop_front());
          popped = 1'b1;
          rv_cnt[G]++;
        end else if (spur[G] && !busy[G] && $urandom_range(1, 0) == 1) begin
          rvalid = 1'b1;
          rdata  = $urandom;
        end
        gnt = ($urandom_range(99, 0) < gnt_pct[G]);
        if (mem_req[G] && gnt) begin
          inflight = pt.size() + (popped ? 1 : 0);
          chk($sformatf("outstanding_ok%0d", G), inflight < MAXO, 1'b1);
          if (exp_addr[G].size() == 0) begin
            nvec++;
            nmis++;
            $display("FAIL grant_addr%0d: got %h with no read expected", G, mem_addr[G]);
          end else begin
            chk($sformatf("grant_addr%0d", G), mem_addr[G], exp_addr[G].pop_front());
          end
          d   = $urandom_range(dmax[G], dmin[G]);
          due = cyc + d;
          if (due <= last_due) due = last_due + 1;
          pd.push_back(mem_word(mem_addr[G]));
          pt.push_back(due);
          last_due = due;
          gnt_log[G].push_back(cyc);
        end
        prev_stall = mem_req[G] && !gnt;
        prev_addr  = mem_addr[G];
      end
    end

    // Response monitor: every response pulse pops one expected line.
    always @(negedge clk) begin : p_monitor
      if (rst_n && ext_rsp[G]) begin
        rsp_cnt[G]++;
        if (exp_line[G].size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL rsp_line%0d: unexpected response %h", G, ext_data[G]);
        end else begin
          last_line[G] = exp_line[G].pop_front();
          chk($sformatf("rsp_line%0d", G), ext_data[G], last_line[G]);
        end
      end
    end
  end

  task automatic push_exp(input int g, input logic [31:0] a);
    logic [1:0]   s;
    logic [1:0]   w;
    logic [127:0] line;
    s = (g == 2) ? 2'd0 : a[1:0];
    for (int k = 0; k < 4; k++) begin
      w = s + 2'(k);
      exp_addr[g].push_back({a[31:2], w});
    end
    for (int k = 0; k < 4; k++) begin
      line[k*32 +: 32] = mem_word({a[31:2], 2'(k)});
    end
    exp_line[g].push_back(line);
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while (busy[g] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_reached%0d", g), busy[g], 1'b0);
  endtask

  task automatic run_fill(input int g, input logic [31:0] a,
                          output int t0, output int trsp, output int bf, output int bl);
    int n = 0;
    wait_idle(g);
    push_exp(g, a);
    ext_addr[g] = a;
    ext_req[g]  = 1'b1;
    t0   = cyc;
    trsp = -1;
    bf   = -1;
    bl   = -1;
    @(negedge clk);
    ext_req[g] = 1'b0;
    while (trsp < 0 && n < 600) begin
      if (busy[g]) begin
        if (bf < 0) bf = cyc;
        bl = cyc;
      end
      if (ext_rsp[g]) trsp = cyc;
      @(negedge clk);
      n++;
    end
    if (busy[g]) bl = cyc;
    chk($sformatf("rsp_seen%0d", g), trsp >= 0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int t0, trsp, bf, bl, base, c, c2, n;
    logic b1, b2;
    logic [31:0] a;

    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      ext_req[g]   = 1'b0;
      ext_addr[g]  = 32'h0;
      gnt_pct[g]   = 100;
      dmin[g]      = 1;
      dmax[g]      = 1;
      spur[g]      = 1'b0;
      rsp_cnt[g]   = 0;
      rv_cnt[g]    = 0;
      last_line[g] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_rsp", ext_rsp[0], 1'b0);
    chk("reset_data", ext_data[0], 128'h0);
    chk("reset_busy", busy[0], 1'b0);
    chk("reset_req", mem_req[0], 1'b0);
    chk("reset_addr", mem_addr[0], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait, four in flight, critical word 1.
    gnt_log[0].delete();
    run_fill(0, 32'h0000_0105, t0, trsp, bf, bl);
    chk("t1_grant_count", gnt_log[0].size(), 4);
    for (int k = 0; k < 4 && k < gnt_log[0].size(); k++)
      chk($sformatf("t1_grant_cycle%0d", k), gnt_log[0][k], t0 + 1 + k);
    chk("t1_rsp_cycle", trsp, t0 + 6);
    chk("t1_busy_first", bf, t0 + 1);
    chk("t1_busy_last", bl, t0 + 6);

    // Zero-wait, one in flight.
    gnt_log[1].delete();
    run_fill(1, 32'h0000_0200, t0, trsp, bf, bl);
    chk("t2_grant_count", gnt_log[1].size(), 4);
    for (int k = 0; k < 4 && k < gnt_log[1].size(); k++)
      chk($sformatf("t2_grant_cycle%0d", k), gnt_log[1][k], t0 + 1 + 2 * k);
    chk("t2_rsp_cycle", trsp, t0 + 9);
    chk("t2_busy_first", bf, t0 + 1);
    chk("t2_busy_last", bl, t0 + 9);

    // Critical word first disabled.
    base = rsp_cnt[2];
    run_fill(2, 32'h0000_0013, t0, trsp, bf, bl);
    chk("t3_rsp_cycle", trsp, t0 + 6);
    repeat (10) @(negedge clk);
    chk("t3_rsp_count", rsp_cnt[2] - base, 1);

    // Request held through the response and three more cycles.
    wait_idle(0);
    a = 32'h0000_0302;
    push_exp(0, a);
    push_exp(0, a);
    base = rsp_cnt[0];
    gnt_log[0].delete();
    ext_addr[0] = a;
    ext_req[0]  = 1'b1;
    t0 = cyc;
    c  = -1;
    n  = 0;
    while (c < 0 && n < 100) begin
      @(negedge clk);
      n++;
      if (ext_rsp[0]) c = cyc;
    end
    chk("held_first_rsp", c, t0 + 6);
    @(negedge clk); b1 = busy[0];
    @(negedge clk); b2 = busy[0];
    @(negedge clk);
    @(negedge clk);
    ext_req[0] = 1'b0;
    chk("held_idle_after_resp", b1, 1'b0);
    chk("held_refill_started", b2, 1'b1);
    c2 = -1;
    n  = 0;
    while (c2 < 0 && n < 100) begin
      if (ext_rsp[0]) c2 = cyc;
      @(negedge clk);
      n++;
    end
    chk("held_second_rsp", c2, c + 7);
    repeat (15) @(negedge clk);
    chk("held_rsp_count", rsp_cnt[0] - base, 2);
    chk("held_grant_count", gnt_log[0].size(), 8);

    // Random grant stalls and read latency, spurious rvalid while idle.
    gnt_pct[0] = 40; dmin[0] = 1; dmax[0] = 5; spur[0] = 1'b1;
    for (int i = 0; i < 200; i++)
      run_fill(0, $urandom, t0, trsp, bf, bl);
    gnt_pct[1] = 40; dmin[1] = 1; dmax[1] = 5; spur[1] = 1'b1;
    for (int i = 0; i < 40; i++)
      run_fill(1, $urandom, t0, trsp, bf, bl);
    repeat (20) @(negedge clk);
    chk("spur_data_hold0", ext_data[0], last_line[0]);
    chk("spur_data_hold1", ext_data[1], last_line[1]);
    chk("spur_idle0", busy[0], 1'b0);

    // Reset in the middle of a fill.
    spur[0] = 1'b0; spur[1] = 1'b0;
    gnt_pct[0] = 100; dmin[0] = 2; dmax[0] = 2;
    wait_idle(0);
    push_exp(0, 32'h0000_0080);
    base = rv_cnt[0];
    ext_addr[0] = 32'h0000_0080;
    ext_req[0]  = 1'b1;
    @(negedge clk);
    ext_req[0] = 1'b0;
    n = 0;
    while (rv_cnt[0] - base < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_two_returns", rv_cnt[0] - base, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_rsp", ext_rsp[0], 1'b0);
    chk("rst_async_data", ext_data[0], 128'h0);
    chk("rst_async_busy", busy[0], 1'b0);
    chk("rst_async_req", mem_req[0], 1'b0);
    chk("rst_async_addr", mem_addr[0], 32'h0);
    for (int g = 0; g < 3; g++) begin
      exp_addr[g].delete();
      exp_line[g].delete();
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_fill(0, 32'h0000_0040, t0, trsp, bf, bl);
    chk("post_rst_rsp_cycle", trsp, t0 + 7);

    repeat (10) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("drain_addr%0d", g), exp_addr[g].size(), 0);
      chk($sformatf("drain_line%0d", g), exp_line[g].size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/srv_icache_refill.md
Name: srv_icache_refill

Overview:
- Line-refill engine between the instruction cache's external miss port and a word-wide instruction memory.
- Accepts a single line-fill request carrying a word address.
- Fetches the four 32-bit words of that line through a request/grant memory port, with up to MAX_OUTST reads in flight, critical word first.
- Returns the assembled 128-bit line to the cache with a one-cycle response pulse.

Parameters:
- MAX_OUTST, 4, max in-flight memory reads (1..4).
- CWF_EN, 1, 1 = start at requested word and wrap mod 4; 0 = always start at word 0.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ext_req_i  input  1  line-fill request from cache (sampled only in IDLE)
- ext_addr_i  input  32  word address; [31:2] line, [1:0] word within line
- ext_rsp_o  output  1  one-cycle pulse: ext_data_o holds the complete line
- ext_data_o  output  128  assembled line; word k in bits [32k+31:32k]
- busy_o  output  1  high in every state except IDLE
- mem_req_o  output  1  memory read request
- mem_addr_o  output  32  word address of current read, {line, word}
- mem_gnt_i  input  1  request accepted when mem_req_o & mem_gnt_i
- mem_rdata_i  input  32  read data
- mem_rvalid_i  input  1  read data valid; exactly one per grant, in grant order, earliest the cycle after its grant

Behaviour:
- Reset is asynchronous, active-low, on rst_n, clocked by clk. All outputs reset to 0: ext_rsp_o, ext_data_o, busy_o, mem_req_o, mem_addr_o. FSM to IDLE; counters and line buffer cleared.
- State IDLE, when ext_req_i=1:
  - capture line=ext_addr_i[31:2];
  - capture start word s = CWF_EN ? ext_addr_i[1:0] : 0;
  - clear issued and returned counters (3-bit, 0..4);
  - go to FILL.
  - ext_data_o is NOT cleared on capture; it holds the previous line until overwritten lane by lane.
- State FILL:
  - mem_req_o = (issued<4) & (issued-returned < MAX_OUTST), computed from registered counters only; no combinational path from mem_rvalid_i or mem_gnt_i to mem_req_o.
  - mem_addr_o = {line, (s+issued) mod 4}, stable while mem_req_o is high and not granted.
  - On grant: issued++.
  - On mem_rvalid_i with returned<issued: write mem_rdata_i into lane (s+returned) mod 4; returned++.
  - Simultaneous grant and rvalid: both counters update in that cycle, so outstanding is unchanged.
  - mem_rvalid_i with returned==issued (spurious) is ignored; no lane write, no count.
  - mem_gnt_i while mem_req_o=0 is ignored.
  - When the rvalid that makes returned=4 is seen, go to RESP at the next edge.
- State RESP: ext_rsp_o=1 for exactly one cycle; ext_data_o holds the full line and stays stable until the next fill writes a lane. Next state IDLE.
- ext_req_i is ignored in FILL and RESP. A request high in any IDLE cycle, including the cycle right after RESP, starts a new fill. The requester must drop ext_req_i once ext_rsp_o is seen.
- Latency, with ext_req_i accepted in cycle T and zero-wait memory (gnt=1, rvalid the cycle after grant):
  - MAX_OUTST=4: grants T+1..T+4, rvalids T+2..T+5, ext_rsp_o in T+6.
  - MAX_OUTST=1: grants T+1,T+3,T+5,T+7, ext_rsp_o in T+9.
- Wrap-around: with s=3 and CWF_EN=1, fetch order is words 3,0,1,2 with addresses {line,3},{line,0},{line,1},{line,2}.
- Reset mid-fill: returns to IDLE immediately and drops mem_req_o. The memory must be reset together with this block; late rvalids after reset fall in IDLE and are ignored.
- Grant stalls: mem_gnt_i=0 for N cycles delays the remaining issues by N; address and request held.

Test Plan:
- MAX_OUTST=4, CWF_EN=1, zero-wait memory, req addr 0x0000_0105 (s=1), mem returns word = 0xA000_0000|addr -> addresses 0x105,0x106,0x107,0x104 on T+1..T+4; ext_rsp_o only in T+6; ext_data_o = {0xA000_0107,0xA000_0106,0xA000_0105,0xA000_0104}.
- MAX_OUTST=1, addr 0x0000_0200 -> mem_req_o never high while one read is outstanding; grants at T+1,T+3,T+5,T+7; ext_rsp_o in T+9; busy_o high T+1..T+9.
- CWF_EN=0, addr 0x0000_0013 -> order 0x10,0x11,0x12,0x13; line correct; single response pulse.
- Random grant stalls (gnt 40% high) and rvalid delay 1..5 cycles, 200 fills -> every line matches the memory model; outstanding never exceeds MAX_OUTST; mem_addr_o stable during stalls; spurious rvalid injected in IDLE causes no change.
- ext_req_i held high through RESP and 3 further cycles -> exactly one new fill starts, in the IDLE cycle after RESP; req pulses during FILL ignored.
- rst_n asserted after 2 of 4 returns -> all outputs 0 asynchronously; after release, a fresh request to 0x0000_0040 completes with the correct line and no stale lanes.
